clock_divider_bank: RTL
=======================

// Module: clock_divider_bank
// PURPOSE
//   Bank of NUM_CH independent clock dividers driven from the single 50 MHz clk_in.
//   Each channel has a runtime-programmable divisor, per-channel enable, a near-50%
//   duty divided clock and a one-cycle tick strobe per period. Divisor changes apply
//   glitch-free at period boundaries. Feeds the KPN process timers/rate generators.
// PARAMETERS
//   NUM_CH      4           number of divider channels (>=1)
//   DIV_W       24          divisor/counter width in bits
//   DEFAULT_DIV 10_000_000  divisor loaded into every channel at reset (< 2**DIV_W)
//   CH_W        derived     max($clog2(NUM_CH),1), localparam
// PORTS
//   clk_in     in   1            system clock
//   reset      in   1            synchronous, active-high reset
//   ch_en      in   NUM_CH       per-channel run enable
//   cfg_valid  in   1            divisor write strobe (single cycle)
//   cfg_ch     in   CH_W         target channel of write
//   cfg_div    in   DIV_W        new divisor value
//   cfg_ack    out  1            one-cycle pulse, write accepted (cycle after cfg_valid)
//   cfg_err    out  1            one-cycle pulse, cfg_ch >= NUM_CH (write dropped)
//   clk_out    out  NUM_CH       divided clocks
//   tick_out   out  NUM_CH       one-cycle strobe per divided period
// BEHAVIOUR
//   One clock; reset is synchronous and active-high. All outputs registered.
//   Reset: every channel active D=DEFAULT_DIV, shadow=DEFAULT_DIV, pending=0, cnt=0;
//     clk_out=0, tick_out=0, cfg_ack=0, cfg_err=0. Reset wins over all other inputs.
//   Per channel i (active divisor D, counter cnt in 0..D-1):
//   - ch_en=1, D>=1: cnt increments each cycle, wraps D-1 -> 0.
//   - clk_out[i] = (cnt >= D>>1): low for D>>1 cycles, high for D-(D>>1) cycles.
//   - tick_out[i] = 1 exactly in the cycle where cnt == D-1; output aligned to cnt.
//   - D=1: clk_out[i] constant 1, tick_out[i] every cycle.
//   - D=0: channel halted: cnt=0, clk_out=0, tick_out=0.
//   - ch_en=0: cnt cleared to 0, clk_out=0, tick_out=0 (sync clear, next cycle).
//   Configuration:
//   - cfg_valid with cfg_ch<NUM_CH: shadow[cfg_ch]<=cfg_div, pending<=1; cfg_ack next cycle.
//   - Shadow->active transfer at the boundary cycle (cnt==D-1) with cnt<=0, or
//     immediately (next cycle) if channel disabled or D=0.
//   - Write in the boundary cycle itself: new cfg_div applies at that boundary.
//   - Multiple writes before a boundary: last write wins; earlier ones never applied.
//   - cfg_ch>=NUM_CH: no state change, cfg_err pulse next cycle, no cfg_ack.
//   - Counter width DIV_W; no overflow possible since cnt < D <= 2**DIV_W-1.
//   - Channels fully independent; one write affects only its target channel.
// TESTING
//   1 Reset, DEFAULT_DIV=4, ch_en=1 -> clk_out[0] pattern 0,0,1,1 repeating; tick on 4th cycle.
//   2 Write D=5 ch1 mid-period (cnt=1 of D=4) -> cfg_ack next cycle; current period
//     finishes at 4 cycles, then 0,0,1,1,1 periods of 5 with tick every 5 cycles.
//   3 Write D=3 then D=6 to ch2 before boundary; also write in boundary cycle -> only last value applied.
//   4 D=1 -> clk_out=1 constant, tick every cycle; D=0 -> outputs 0, cnt held 0; D=2 -> toggles.
//   5 cfg_ch=NUM_CH -> cfg_err pulse, no ack, no channel changes; drop ch_en mid-period -> outputs 0 next cycle, restart from cnt=0.
//   6 Assert reset mid-period with pending write -> all outputs 0, divisors back to DEFAULT_DIV.

Source files
------------

// File: rtl/clock_divider_bank.sv
// Bank of independent programmable clock dividers sharing one input clock.
// Each channel produces a near-50% divided clock plus a one-cycle tick per period.
module clock_divider_bank #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 24,
    parameter int DEFAULT_DIV = 10_000_000,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              cfg_ack,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick_out
);

    localparam logic [DIV_W-1:0] DEF_D = DIV_W'(DEFAULT_DIV);

    logic [NUM_CH-1:0] hit;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_ack <= cfg_valid && (|hit);
            cfg_err <= cfg_valid && !(|hit);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DIV_W-1:0] cnt, d_act, shadow;
        logic [DIV_W-1:0] cnt_n, d_n, shadow_n;
        logic             pending, pending_n;
        logic             apply, run, clk_n, tick_n, clk_q, tick_q;

        assign hit[g] = cfg_valid && (cfg_ch == CH_W'(g));

        // A write landing in the boundary cycle is folded in before the
        // transfer decision, so it takes effect at that same boundary.
        always_comb begin
            apply    = 1'b0;
            cnt_n    = cnt + DIV_W'(1);
            shadow_n = hit[g] ? cfg_div : shadow;
            if (!ch_en[g] || (d_act == '0)) begin
                cnt_n = '0;
                apply = 1'b1;
            end else if (cnt == d_act - DIV_W'(1)) begin
                cnt_n = '0;
                apply = 1'b1;
            end
            d_n       = (apply && (hit[g] || pending)) ? shadow_n : d_act;
            pending_n = (hit[g] || pending) && !apply;
            run       = ch_en[g] && (d_n != '0);
            clk_n     = run && (cnt_n >= (d_n >> 1));
            tick_n    = run && (cnt_n == d_n - DIV_W'(1));
        end

        always_ff @(posedge clk_in) begin
            if (reset) begin
                cnt     <= '0;
                d_act   <= DEF_D;
                shadow  <= DEF_D;
                pending <= 1'b0;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                cnt     <= cnt_n;
                d_act   <= d_n;
                shadow  <= shadow_n;
                pending <= pending_n;
                clk_q   <= clk_n;
                tick_q  <= tick_n;
            end
        end

        assign clk_out[g]  = clk_q;
        assign tick_out[g] = tick_q;
    end

endmodule
